// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flop, LSB first; SERIAL_ADDER_SUB_EN adds a subtract port.
// Latency: done pulses in the cycle after the WIDTH-th edge that follows the start-accepting edge.
// Backpressure: none; start is sampled only in IDLE and ignored while busy or done.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             accept;
    logic             last_bit;
    logic             s_bit;
    logic             c_nxt;
    logic [WIDTH-1:0] b_load;
    logic             c_load;
    logic [WIDTH-1:0] res_nxt;

    // Subtraction is a + ~b + 1, so the operand is inverted at capture and the datapath stays shared.
`ifdef SERIAL_ADDER_SUB_EN
    assign b_load = sub ? ~b : b;
    assign c_load = sub ? 1'b1 : cin;
`else
    assign b_load = b;
    assign c_load = cin;
`endif

    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign s_bit    = a_sh[0] ^ b_sh[0] ^ carry;
    assign c_nxt    = (a_sh[0] & b_sh[0]) | ((a_sh[0] ^ b_sh[0]) & carry);
    assign res_nxt  = {s_bit, res[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b_load;
            res   <= '0;
            cnt   <= '0;
            carry <= c_load;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            res   <= res_nxt;
            carry <= c_nxt;
            if (last_bit) begin
                // Carry into the MSB is the flop value; carry out of it is c_nxt.
                sum  <= res_nxt;
                cout <= c_nxt;
                ovf  <= carry ^ c_nxt;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed-vector bench for serial_adder at WIDTH=8; subtract vectors run when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub = 1'b0;
`endif
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;

    int nvec  = 0;
    int nfail = 0;

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Starts one operation and returns the number of edges from the accepting edge to done.
    task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic vc, output int lat);
        @(negedge clk);
        a = va;
        b = vb;
        cin = vc;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 99;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    vec_t tbl[7];
`ifdef SERIAL_ADDER_SUB_EN
    vec_t stbl[2];
`endif

    initial begin
        int lat;
        int ndone;
        int first_d;
        int second_d;

        tbl[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
        tbl[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[4] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};
        tbl[5] = '{8'h3C, 8'h44, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
`ifdef SERIAL_ADDER_SUB_EN
        stbl[0] = '{8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0};
        stbl[1] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
`endif

        // Reset state
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_sum",  32'(sum),  32'd0);
        check("reset_cout", 32'(cout), 32'd0);
        check("reset_ovf",  32'(ovf),  32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].cin, lat);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'd8);
            check($sformatf("v%0d_sum", i),  32'(sum),  32'(tbl[i].sum));
            check($sformatf("v%0d_cout", i), 32'(cout), 32'(tbl[i].cout));
            check($sformatf("v%0d_ovf", i),  32'(ovf),  32'(tbl[i].ovf));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_done_one_cycle", i), 32'(done), 32'd0);
        end

        // Result holds while the next operation runs; start and operand changes mid-run are ignored.
        @(negedge clk);
        a = 8'h12;
        b = 8'h34;
        cin = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
            if (k == 3) begin
                check("hold_sum_midrun", 32'(sum), 32'hFF);
                check("busy_midrun", 32'(busy), 32'd1);
                a = 8'hFF;
                b = 8'hFF;
                cin = 1'b1;
                start = 1'b1;
            end
            if (k == 4) start = 1'b0;
        end
        check("restart_single_done", 32'(ndone), 32'd1);
        check("restart_sum", 32'(sum), 32'h46);
        check("restart_cout", 32'(cout), 32'd0);

        // Asynchronous reset in the middle of a run.
        run_op(8'h0F, 8'h01, 1'b0, lat);
        check("pre_reset_sum", 32'(sum), 32'h10);
        @(posedge clk);
        @(negedge clk);
        a = 8'h01;
        b = 8'h01;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_sum",  32'(sum),  32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_cout", 32'(cout), 32'd0);
        check("arst_ovf",  32'(ovf),  32'd0);
        ndone = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("arst_no_done", 32'(ndone), 32'd0);
        run_op(8'h03, 8'h04, 1'b0, lat);
        check("post_reset_latency", 32'(lat), 32'd8);
        check("post_reset_sum", 32'(sum), 32'h07);
        @(posedge clk);

        // Held start gives back-to-back operations every WIDTH+2 cycles.
        @(negedge clk);
        a = 8'h01;
        b = 8'h02;
        cin = 1'b0;
        start = 1'b1;
        first_d = -1;
        second_d = -1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                if (first_d < 0) first_d = k;
                else if (second_d < 0) second_d = k;
            end
        end
        start = 1'b0;
        check("b2b_first_done", 32'(first_d), 32'd9);
        check("b2b_period", 32'(second_d - first_d), 32'd10);
        check("b2b_sum", 32'(sum), 32'h03);
        repeat (12) @(posedge clk);

`ifdef SERIAL_ADDER_SUB_EN
        foreach (stbl[i]) begin
            sub = 1'b1;
            run_op(stbl[i].a, stbl[i].b, stbl[i].cin, lat);
            sub = 1'b0;
            check($sformatf("s%0d_latency", i), 32'(lat), 32'd8);
            check($sformatf("s%0d_sum", i),  32'(sum),  32'(stbl[i].sum));
            check($sformatf("s%0d_cout", i), 32'(cout), 32'(stbl[i].cout));
            check($sformatf("s%0d_ovf", i),  32'(ovf),  32'(stbl[i].ovf));
            @(posedge clk);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
